// File: rtl/stream_unpatch.sv
// Re-serialises block-wise processed data back into a per-pixel raster stream.
// A two-bank line buffer holds one block row while the previous one is read out.
module stream_unpatch #(
   parameter int BIT_WIDTH    = 8,
   parameter int IMAGE_HEIGHT = 8,
   parameter int IMAGE_WIDTH  = 8,
   parameter int FRAME_HEIGHT = 12,
   parameter int FRAME_WIDTH  = 12,
   parameter int BLOCK_HEIGHT = 2,
   parameter int BLOCK_WIDTH  = 2
) (
   input  logic                                          clock,
   input  logic                                          rst,
   input  logic                                          enable,
   input  logic [0:BIT_WIDTH*BLOCK_WIDTH*BLOCK_HEIGHT-1] in_block,
   input  logic [8:0]                                    in_vcnt,
   input  logic [9:0]                                    in_hcnt,
   output logic [BIT_WIDTH-1:0]                          out_pixel,
   output logic [8:0]                                    out_vcnt,
   output logic [9:0]                                    out_hcnt
);

   localparam int ROW_W    = (BLOCK_HEIGHT > 1) ? $clog2(BLOCK_HEIGHT) : 1;
   localparam int COL_W    = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
   localparam int BANK_BIT = $clog2(BLOCK_HEIGHT);
   // Active column bound never exceeds the frame, so a mismatched parameter set cannot overrun a line.
   localparam int ACTIVE_W = (FRAME_WIDTH > IMAGE_WIDTH) ? IMAGE_WIDTH : FRAME_WIDTH;

   logic [BIT_WIDTH-1:0] r_buf [0:1][0:BLOCK_HEIGHT-1][0:IMAGE_WIDTH-1];
   logic                 r_primed;

   logic                 w_write;
   logic                 w_wrBank;
   logic                 w_rdBank;
   logic                 w_active;
   logic [COL_W-1:0]     w_wrCol;
   logic [COL_W-1:0]     w_rdCol;
   logic [ROW_W-1:0]     w_rdRow;
   logic [8:0]           w_ov;

   assign w_write  = enable
                     && (in_vcnt < 9'(IMAGE_HEIGHT))
                     && (in_hcnt < 10'(IMAGE_WIDTH))
                     && ((in_vcnt % 9'(BLOCK_HEIGHT)) == 9'd0)
                     && ((in_hcnt % 10'(BLOCK_WIDTH)) == 10'd0);
   assign w_wrBank = in_vcnt[BANK_BIT];
   assign w_wrCol  = COL_W'(in_hcnt);

   // Rows above the first block row wrap back into the vertical blanking of the previous frame.
   assign w_ov     = (in_vcnt >= 9'(BLOCK_HEIGHT)) ? in_vcnt - 9'(BLOCK_HEIGHT)
                                                   : in_vcnt + 9'(FRAME_HEIGHT - BLOCK_HEIGHT);
   assign w_active = (w_ov < 9'(IMAGE_HEIGHT)) && (in_hcnt < 10'(ACTIVE_W)) && r_primed;
   assign w_rdBank = w_ov[BANK_BIT];
   assign w_rdRow  = ROW_W'(w_ov % 9'(BLOCK_HEIGHT));
   assign w_rdCol  = w_active ? COL_W'(in_hcnt) : '0;

   always_ff @(posedge clock) begin
      if (w_write) begin
         for (int v = 0; v < BLOCK_HEIGHT; v++) begin
            for (int h = 0; h < BLOCK_WIDTH; h++) begin
               r_buf[w_wrBank][ROW_W'(v)][w_wrCol + COL_W'(h)] <=
                  in_block[(v*BLOCK_WIDTH+h)*BIT_WIDTH +: BIT_WIDTH];
            end
         end
      end
   end

   // Only a fresh top-left write arms output, so stale lines after reset are never shown.
   always_ff @(posedge clock) begin
      if (rst) begin
         r_primed <= 1'b0;
      end else if (w_write && (in_vcnt == 9'd0) && (in_hcnt == 10'd0)) begin
         r_primed <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         out_pixel <= '0;
         out_vcnt  <= '0;
         out_hcnt  <= '0;
      end else if (enable) begin
         out_pixel <= w_active ? r_buf[w_rdBank][w_rdRow][w_rdCol] : '0;
         out_vcnt  <= w_ov;
         out_hcnt  <= in_hcnt;
      end
   end

endmodule

// File: tb/tb_stream_unpatch.sv
// Drives whole frames of blocks into stream_unpatch and checks every output cycle
// against a full-image reference model, plus a few hand-computed pixels.
module tb_stream_unpatch;

   localparam int BITW = 8;
   localparam int IH   = 8;
   localparam int IW   = 8;
   localparam int FH   = 12;
   localparam int FW   = 12;
   localparam int BH   = 2;
   localparam int BWD  = 2;
   localparam int NB   = BITW*BH*BWD;

   logic            clock = 1'b0;
   logic            rst;
   logic            enable;
   logic [0:NB-1]   inBlock;
   logic [8:0]      inVcnt;
   logic [9:0]      inHcnt;
   logic [BITW-1:0] outPixel;
   logic [8:0]      outVcnt;
   logic [9:0]      outHcnt;

   int testsRun    = 0;
   int testsFailed = 0;

   int         img [0:IH-1][0:IW-1];
   bit         mPrimed = 1'b0;
   int         mPix = 0;
   int         mV   = 0;
   int         mH   = 0;
   int         frameNo = 0;

   bit nextCheck = 1'b0, curCheck = 1'b0;
   int nextPix, nextV, nextH, curPix, curV, curH;
   bit nextLit = 1'b0, curLit = 1'b0;
   int nextLitPix, nextLitV, nextLitH, curLitPix, curLitV, curLitH;

   // {frame, in_vcnt, in_hcnt, out_pixel, out_vcnt, out_hcnt} one cycle after that input
   int litTab [0:17][0:5] = '{
      '{0, 2, 0, 11, 0, 0}, '{0, 2, 1, 12, 0, 1}, '{0, 3, 0, 21, 1, 0},
      '{0, 3, 1, 22, 1, 1}, '{0, 0, 3, 0, 10, 3}, '{0, 4, 9, 0, 2, 9},
      '{0, 4, 5, 36, 2, 5}, '{1, 4, 0, 32, 2, 0}, '{1, 6, 2, 48, 4, 2},
      '{1, 2, 7, 16, 0, 7}, '{1, 9, 7, 64, 7, 7}, '{2, 3, 1, 85, 1, 1},
      '{2, 9, 6, 85, 7, 6}, '{3, 5, 6, 47, 3, 6}, '{4, 4, 1, 0, 2, 1},
      '{4, 6, 4, 0, 4, 4},  '{5, 2, 0, 16, 0, 0}, '{5, 3, 1, 16, 1, 1}
   };

   stream_unpatch #(
      .BIT_WIDTH(BITW), .IMAGE_HEIGHT(IH), .IMAGE_WIDTH(IW),
      .FRAME_HEIGHT(FH), .FRAME_WIDTH(FW), .BLOCK_HEIGHT(BH), .BLOCK_WIDTH(BWD)
   ) dut (
      .clock(clock), .rst(rst), .enable(enable), .in_block(inBlock),
      .in_vcnt(inVcnt), .in_hcnt(inHcnt),
      .out_pixel(outPixel), .out_vcnt(outVcnt), .out_hcnt(outHcnt)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s frame %0d: got %0d, expected %0d", name, frameNo, act, exp);
      end
   endtask

   // Pixel content of each test pattern, as a function of absolute image position.
   function automatic logic [0:NB-1] blockFor(input int mode, input int vc, input int hc);
      logic [0:NB-1] b;
      bit            aligned;
      int            val;
      aligned = (vc % BH == 0) && (hc % BWD == 0);
      b = '0;
      for (int v = 0; v < BH; v++) begin
         for (int h = 0; h < BWD; h++) begin
            case (mode)
               0:       val = 11 + 10*(vc+v) + (hc+h);
               1:       val = 16 * ((vc+v)/BH + 1);
               2:       val = aligned ? 'h55 : 'hFF;
               default: val = 'hEE;
            endcase
            b[(v*BWD+h)*BITW +: BITW] = BITW'(val);
         end
      end
      return b;
   endfunction

   // Model: whole-image store plus the output coordinate rules; expectation refers to the next edge.
   task automatic applyStimulus(input bit en, input bit rs, input int vc, input int hc,
                                input logic [0:NB-1] blk, input bit useLit,
                                input int lp, input int lv, input int lh);
      int ov;
      rst     = rs;
      enable  = en;
      inVcnt  = 9'(vc);
      inHcnt  = 10'(hc);
      inBlock = blk;
      if (rs) begin
         mPix = 0; mV = 0; mH = 0; mPrimed = 1'b0;
      end else if (en) begin
         ov   = (vc >= BH) ? vc - BH : vc + FH - BH;
         mV   = ov;
         mH   = hc;
         mPix = (ov < IH && hc < IW && mPrimed) ? img[ov][hc] : 0;
      end
      if (en && vc < IH && hc < IW && vc % BH == 0 && hc % BWD == 0) begin
         for (int v = 0; v < BH; v++)
            for (int h = 0; h < BWD; h++)
               img[vc+v][hc+h] = int'(blk[(v*BWD+h)*BITW +: BITW]);
         if (vc == 0 && hc == 0 && !rs) mPrimed = 1'b1;
      end
      nextPix = mPix; nextV = mV; nextH = mH; nextCheck = 1'b1;
      nextLit = useLit; nextLitPix = lp; nextLitV = lv; nextLitH = lh;
      @(posedge clock);
      #1;
   endtask

   task automatic runFrame(input int mode, input int stallV, input int stallH,
                           input int rstV, input int rstH);
      bit useLit;
      int lp, lv, lh;
      for (int v = 0; v < FH; v++) begin
         for (int h = 0; h < FW; h++) begin
            if (v == stallV && h == stallH) begin
               for (int s = 0; s < 5; s++)
                  applyStimulus(1'b0, 1'b0, v, h, blockFor(3, v, h), 1'b1, 33, 2, 2);
            end
            useLit = 1'b0; lp = 0; lv = 0; lh = 0;
            for (int k = 0; k < 18; k++) begin
               if (litTab[k][0] == frameNo && litTab[k][1] == v && litTab[k][2] == h) begin
                  useLit = 1'b1; lp = litTab[k][3]; lv = litTab[k][4]; lh = litTab[k][5];
               end
            end
            if (v == rstV && h == rstH) begin
               useLit = 1'b1; lp = 0; lv = 0; lh = 0;
            end
            applyStimulus(1'b1, (v == rstV && h == rstH), v, h, blockFor(mode, v, h),
                          useLit, lp, lv, lh);
         end
      end
      frameNo++;
   endtask

   // Single checker: latch the expectation at the edge, compare mid-cycle.
   initial begin
      forever begin
         @(posedge clock);
         curCheck = nextCheck; curPix = nextPix; curV = nextV; curH = nextH;
         curLit = nextLit; curLitPix = nextLitPix; curLitV = nextLitV; curLitH = nextLitH;
         @(negedge clock);
         if (curCheck) begin
            checkOutput("model_pixel", 32'(outPixel), 32'(curPix));
            checkOutput("model_vcnt",  32'(outVcnt),  32'(curV));
            checkOutput("model_hcnt",  32'(outHcnt),  32'(curH));
         end
         if (curLit) begin
            checkOutput("literal_pixel", 32'(outPixel), 32'(curLitPix));
            checkOutput("literal_vcnt",  32'(outVcnt),  32'(curLitV));
            checkOutput("literal_hcnt",  32'(outHcnt),  32'(curLitH));
         end
      end
   end

   initial begin
      rst = 1'b1; enable = 1'b1; inBlock = '0; inVcnt = '0; inHcnt = '0;
      for (int r = 0; r < IH; r++)
         for (int c = 0; c < IW; c++)
            img[r][c] = 0;
      @(posedge clock);
      #1;
      applyStimulus(1'b1, 1'b1, 0, 0, '0, 1'b0, 0, 0, 0);
      applyStimulus(1'b1, 1'b1, 0, 0, '0, 1'b1, 0, 0, 0);
      frameNo = 0;
      runFrame(0, -1, -1, -1, -1);
      runFrame(1, -1, -1, -1, -1);
      runFrame(2, -1, -1, -1, -1);
      runFrame(0,  4,  3, -1, -1);
      runFrame(0, -1, -1,  4,  0);
      runFrame(1, -1, -1, -1, -1);
      applyStimulus(1'b1, 1'b0, 0, 0, blockFor(1, 0, 0), 1'b0, 0, 0, 0);
      @(posedge clock);
      #1;
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
